xadc_da2_sched: RTL

Sequencer between the XADC wizard's DRP port and the PmodDA2 reference driver. It turns each XADC end-of-conversion into a DRP read and routes the 12-bit result into one of two sample slots. It launches rate-limited DA2 transfers of both slots with a start/done handshake. It replaces the direct wiring of `den_in` to `eoc_out` and of the DAC start to a free clock divider, and adds overrun and timeout reporting.

---
 rtl/xadc_da2_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/xadc_da2_sched.sv
// Sequencer between the XADC DRP port and the PmodDA2 driver: reads each conversion
// into slot A or B, then launches rate-limited DAC transfers with a done/timeout handshake.
module xadc_da2_sched #(
  parameter logic [4:0] CH_A         = 5'h03,
  parameter logic [4:0] CH_B         = 5'h10,
  parameter int         UPDATE_DIV   = 20,
  parameter int         DONE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eoc,
  input  logic [4:0]  channel,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic        dac_start,
  input  logic        dac_done,
  output logic [11:0] dac_data1,
  output logic [11:0] dac_data2,
  output logic        overrun,
  output logic        dac_timeout
);

  localparam int CNT_W = $clog2(UPDATE_DIV);
  localparam int TMR_W = $clog2(DONE_TIMEOUT);

  typedef enum logic [1:0] {R_IDLE, R_READ, R_WAIT} r_state_t;
  typedef enum logic       {D_IDLE, D_BUSY}         d_state_t;

  r_state_t          r_state, r_next;
  d_state_t          d_state, d_next;
  logic [4:0]        ch_q;
  logic [11:0]       slot_a, slot_b;
  logic              fresh;
  logic [CNT_W-1:0]  cnt;
  logic [TMR_W-1:0]  tmr;
  logic              latch_ch, capture, drop, to_a, to_b;
  logic              tick, launch, give_up;

  // The XADC leaves the four LSBs of a DRP result as padding.
  logic unused_drp_lsbs;
  assign unused_drp_lsbs = ^drp_do[3:0];

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    r_next   = r_state;
    latch_ch = 1'b0;
    capture  = 1'b0;
    drop     = 1'b0;
    case (r_state)
      R_IDLE: if (eoc) begin
        latch_ch = 1'b1;
        r_next   = R_READ;
      end
      R_READ: begin
        drop   = eoc;
        r_next = R_WAIT;
      end
      R_WAIT: if (drp_drdy) begin
        capture = 1'b1;
        if (eoc) begin
          latch_ch = 1'b1;
          r_next   = R_READ;
        end else begin
          r_next = R_IDLE;
        end
      end else begin
        drop = eoc;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign to_a      = capture && (ch_q == CH_A);
  assign to_b      = capture && (ch_q == CH_B);
  assign drp_den   = (r_state == R_READ);
  assign drp_daddr = drp_den ? {2'b00, ch_q} : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      ch_q    <= '0;
      slot_a  <= '0;
      slot_b  <= '0;
      overrun <= 1'b0;
    end else begin
      r_state <= r_next;
      if (latch_ch) ch_q   <= channel;
      if (to_a)     slot_a <= drp_do[15:4];
      if (to_b)     slot_b <= drp_do[15:4];
      if (drop)     overrun <= 1'b1;
    end
  end

  assign tick = (cnt == CNT_W'(UPDATE_DIV - 1));

  // tmr counts cycles since the dac_start cycle (0 there); done is honoured from 2 on.
  always_comb begin
    d_next  = d_state;
    launch  = 1'b0;
    give_up = 1'b0;
    case (d_state)
      D_IDLE: if (tick && fresh) begin
        launch = 1'b1;
        d_next = D_BUSY;
      end
      D_BUSY: if (dac_done && (tmr >= TMR_W'(2))) begin
        d_next = D_IDLE;
      end else if (tmr == TMR_W'(DONE_TIMEOUT - 1)) begin
        give_up = 1'b1;
        d_next  = D_IDLE;
      end
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_state     <= D_IDLE;
      cnt         <= '0;
      tmr         <= '0;
      fresh       <= 1'b0;
      dac_start   <= 1'b0;
      dac_data1   <= '0;
      dac_data2   <= '0;
      dac_timeout <= 1'b0;
    end else begin
      d_state   <= d_next;
      cnt       <= tick ? '0 : cnt + CNT_W'(1);
      dac_start <= launch;
      if (launch) begin
        dac_data1 <= slot_a;
        dac_data2 <= slot_b;
        tmr       <= '0;
      end else if (d_state == D_BUSY) begin
        tmr <= tmr + TMR_W'(1);
      end
      // A capture coinciding with a launch keeps fresh set for the next tick.
      if (to_a || to_b) fresh <= 1'b1;
      else if (launch)  fresh <= 1'b0;
      if (give_up) dac_timeout <= 1'b1;
    end
  end

endmodule
